lsu32: RTL and testbench
========================

# lsu32

Load/store unit for the RV32I core, directly downstream of the 32-bit ALU. It takes the ALU result as the effective address of a load or store and runs a single-outstanding request/ready transaction on a 32-bit word-addressed data bus. It returns sign- or zero-extended load data for register writeback. It flags misaligned or illegal accesses and bus timeouts instead of hanging the core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles spent in BUS waiting for mem_ready before the access is aborted with an error. Range 1..255.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents an access this cycle.
- req_ready  out  1  high only in IDLE; an access is accepted when req_valid && req_ready.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign field.
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rs2).
- done  out  1  one-cycle pulse: access complete.
- err  out  1  valid with done: misaligned, illegal funct3, or timeout.
- load_data  out  32  extended load result, valid with done. It is 0 for stores and errors.
- mem_req  out  1  bus request, held until mem_ready.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  bus completes the access this cycle.
- mem_rdata  in  32  read word, valid when mem_ready is high.

## Operation
- **State machine: IDLE, BUS, DONE.**
  - IDLE → BUS on accept of a legal, aligned access. All request fields are captured into registers.
  - IDLE → DONE on accept of an illegal or misaligned access, with err=1. No bus activity occurs.
  - BUS → DONE on mem_ready=1, or when the wait counter reaches TIMEOUT_CYCLES (err=1).
  - DONE → IDLE unconditionally. DONE lasts exactly one cycle, with done=1.
- **Legal funct3.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- **Alignment.**
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - Byte accesses are always aligned.
- **Bus outputs.**
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and stable for the whole of BUS.
  - mem_req is 0 in IDLE and DONE.
- **Byte enables:** byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Loads drive the same enables.
- **Store data:** SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- **Load extraction.**
  - On mem_ready, select the byte at addr[1:0] or the half at addr[1]. LW takes the whole word.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - The result is registered into load_data for the DONE cycle.
- **Outputs outside DONE:** load_data and err are 0.
- **Stray inputs:** mem_ready outside BUS is ignored. req_valid outside IDLE is ignored (req_ready=0).
- **Timeout:**
  - The 8-bit wait counter clears on entry to BUS and increments on each BUS cycle with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES, the unit drops mem_req and goes to DONE with err=1 and load_data=0.
  - If mem_ready and the timeout threshold coincide, mem_ready wins and the access completes normally.

## Timing
- **Reset values:** state IDLE; req_ready=1 from the first cycle after reset; done, err, load_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata all 0.
- **Reset mid-access:** if rst is asserted in BUS or DONE, mem_req and done are 0 from the next edge and no completion is reported.
- **Legal access latency:**
  - Accept at cycle 0, mem_req high from cycle 1.
  - mem_ready in cycle k (k≥1) gives done in cycle k+1.
  - Zero-wait bus: done in cycle 2; next accept possible in cycle 3.
- **Error latency:** an illegal or misaligned access accepted in cycle 0 gives done=1, err=1 in cycle 1, with mem_req never asserted.
- **Timeout latency:** mem_req stays high for TIMEOUT_CYCLES cycles, then done/err appear in the following cycle.

## Test plan
- **LW:** addr=0x100, mem_rdata=0xDEADBEEF, mem_ready in the first BUS cycle → mem_be=1111, mem_addr=0x100, done in cycle 2 with load_data=0xDEADBEEF, err=0.
- **LB/LBU at offset 3:** addr=0x203, mem_rdata=0x80FF1234.
  - LB → mem_be=1000, load_data=0xFFFFFF80.
  - LBU → load_data=0x00000080.
- **SH at offset 2:** addr=0x302, wdata=0x1234ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x300, load_data=0 at done.
- **Misaligned and illegal:**
  - LH at addr=0x401 → done/err=1 in cycle 1, mem_req stays 0.
  - funct3=011 load → same response.
- **Timeout:** TIMEOUT_CYCLES=4, mem_ready held 0 → mem_req high exactly 4 cycles, then done=1, err=1, load_data=0, then req_ready=1.
- **Reset mid-BUS:** assert rst while mem_req=1 → next cycle mem_req=0, done=0, req_ready=1. A later mem_ready pulse produces no done.

Source files
------------

// File: rtl/lsu32.sv
// ---------------------------------------------------------------------------
// lsu32 - load/store unit for an RV32I core.
//
// Takes the ALU result as the effective address of a load or store and runs a
// single-outstanding request/ready transaction on a 32-bit word-addressed
// data bus. Loads return sign- or zero-extended data. Misaligned or illegal
// accesses and bus timeouts are reported through err instead of stalling.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req_valid    execute stage presents an access
//   req_ready    unit idle, access accepted on req_valid && req_ready
//   is_store     1 = store, 0 = load
//   funct3       RV32I width/sign field
//   addr         effective address
//   wdata        store data (rs2)
//   done         one-cycle completion pulse
//   err          misaligned / illegal funct3 / timeout, valid with done
//   load_data    extended load result, valid with done (0 for stores/errors)
//   mem_req      bus request, held until mem_ready or timeout
//   mem_we       bus write enable
//   mem_addr     word-aligned bus address
//   mem_be       byte enables
//   mem_wdata    lane-replicated store data
//   mem_ready    bus completes the access this cycle
//   mem_rdata    read word, valid with mem_ready
// ---------------------------------------------------------------------------
module lsu32 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // The wait counter holds the number of completed BUS cycles without
    // mem_ready; the last permitted BUS cycle is the one where it equals
    // TIMEOUT_CYCLES-1, so mem_req is high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // funct3 legality: loads allow 000/001/010/100/101, stores 000/001/010.
    function automatic logic legal_f(input logic st, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~st;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment check; only meaningful for legal funct3 codes.
    function automatic logic aligned_f(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables from access size and byte offset.
    function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the enabled lanes carry it.
    function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            2'b10:   r = wd;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Select the addressed lane from the read word and extend it.
    function automatic logic [31:0] extract_f(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'h00;
        endcase
        if (off[1]) begin
            h = rd[31:16];
        end else begin
            h = rd[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = rd;
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e      state_q,     state_d;
    logic        req_ready_q, req_ready_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;
    logic [31:0] load_data_q, load_data_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  off_q,       off_d;
    logic [2:0]  f3_q,        f3_d;
    logic [7:0]  cnt_q,       cnt_d;

    logic        acc_ok_s;

    assign acc_ok_s = legal_f(is_store, funct3) & aligned_f(funct3, addr[1:0]);

    // Next-state and next-output logic for the IDLE/BUS/DONE machine.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_data_d = 32'h0000_0000;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        off_d       = off_q;
        f3_d        = f3_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (acc_ok_s) begin
                        state_d     = S_BUS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_f(funct3, addr[1:0]);
                        if (is_store) begin
                            mem_wdata_d = wdata_f(funct3, wdata);
                        end else begin
                            mem_wdata_d = 32'h0000_0000;
                        end
                        off_d       = addr[1:0];
                        f3_d        = funct3;
                        cnt_d       = 8'd0;
                    end else begin
                        // Rejected without touching the bus.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_BUS: begin
                // mem_ready takes priority over a coincident timeout.
                if (mem_ready) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (mem_we_q) begin
                        load_data_d = 32'h0000_0000;
                    end else begin
                        load_data_d = extract_f(f3_q, off_q, mem_rdata);
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (state_d == S_DONE) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_be_d    = 4'b0000;
                    mem_wdata_d = 32'h0000_0000;
                end else begin
                    mem_req_d   = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 32'h0000_0000;
                mem_be_d    = 4'b0000;
                mem_wdata_d = 32'h0000_0000;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // State and output register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign load_data = load_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu32.sv
module tb_lsu32;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    lsu32 #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .done(done), .err(err), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_err", {31'd0, err}, {31'd0, e.err});
                chk("done_load_data", load_data, e.ld);
                chk("done_cycle", cyc, e.cyc);
            end
        end else if (!rst) begin
            if (err !== 1'b0 || load_data !== 32'h0) begin
                checks++;
                errors++;
                $display("FAIL idle_outputs: got err=%0b load_data=0x%08h expected 0/0", err, load_data);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // One access; wait_n BUS cycles without mem_ready before completing.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int wait_n,
                          input logic exp_err, input logic [31:0] exp_ld,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_t e;
        wait_ready();
        e.err = exp_err;
        e.ld  = exp_ld;
        e.cyc = exp_err ? cyc + 1 : cyc + 2 + wait_n;
        sb.push_back(e);
        is_store = st; funct3 = f3; addr = a; wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_err) begin
            chk("err_no_mem_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk);
            chk("err_no_mem_req2", {31'd0, mem_req}, 32'd0);
        end else begin
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, st});
            chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
            if (st) chk("mem_wdata", mem_wdata, exp_wd);
            for (int i = 0; i < wait_n; i++) begin
                @(negedge clk);
                chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
                chk("mem_addr_hold", mem_addr, {a[31:2], 2'b00});
            end
            mem_ready = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);

        // LW, zero-wait
        access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        // LB / LBU at offset 3
        access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0);
        access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1, 1'b0, 32'h0000_0080, 4'b1000, 32'h0);
        // LH upper half (sign), LHU lower half
        access(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h80FF_1234, 2, 1'b0, 32'hFFFF_80FF, 4'b1100, 32'h0);
        access(1'b0, 3'b101, 32'h0000_0200, 32'h0, 32'h80FF_9234, 0, 1'b0, 32'h0000_9234, 4'b0011, 32'h0);
        // SH at offset 2, SB at offset 1, SW
        access(1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 4'b1100, 32'hABCD_ABCD);
        access(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 1, 1'b0, 32'h0, 4'b0010, 32'hA5A5_A5A5);
        access(1'b1, 3'b010, 32'h1234_5678, 32'hCAFE_F00D, 32'h0, 0, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D);
        // mem_ready coinciding with the timeout threshold: completes normally
        access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0BAD_CAFE, TMO - 1, 1'b0, 32'h0BAD_CAFE, 4'b1111, 32'h0);
        // misaligned / illegal
        access(1'b0, 3'b001, 32'h0000_0401, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
        access(1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
        access(1'b1, 3'b100, 32'h0000_0400, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
        access(1'b1, 3'b010, 32'h0000_0402, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);

        // Timeout: mem_ready held low
        wait_ready();
        e.err = 1'b1; e.ld = 32'h0; e.cyc = cyc + TMO + 1;
        sb.push_back(e);
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_mem_req_high", {31'd0, mem_req}, 32'd1);
            @(negedge clk);
        end
        chk("tmo_mem_req_low", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("tmo_req_ready", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of BUS
        wait_ready();
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0600;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_mem_req_low", {31'd0, mem_req}, 32'd0);
        chk("rstmid_done_low", {31'd0, done}, 32'd0);
        chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("stray_ready_no_req", {31'd0, mem_req}, 32'd0);
        repeat (4) @(negedge clk);

        // Back-to-back after reset still works
        access(1'b0, 3'b000, 32'h0000_0700, 32'h0, 32'h0000_007F, 0, 1'b0, 32'h0000_007F, 4'b0001, 32'h0);
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
